// File: rtl/megacart_nvram_ctrl.sv
// MegaCart NVRAM load/save sequencer: moves the packed 5K image between the SD
// image interface and the sparse 8K NVRAM region in SDRAM, one 512-byte sector at a time.
module megacart_nvram_ctrl #(
  parameter logic [22:0] NVRAM_BASE = 23'h400000,
  parameter int          SECTORS    = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        img_readonly,
  input  logic        save_req,
  input  logic        nvram_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        busy,
  output logic        dirty
);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_XFER, LD_COPY, SV_FILL, SV_REQ, SV_XFER
  } state_t;

  state_t     state;
  logic       mounted;
  logic       pending_load;
  logic       pending_save;
  logic [3:0] sec;
  logic [8:0] idx;
  logic       phase;
  logic [7:0] sbuf [512];

  logic last_sec;
  logic last_byte;
  assign last_sec  = (sec == 4'(SECTORS - 1));
  assign last_byte = (idx == 9'd511);

  // Image offsets 0x000-0xBFF land at NVRAM 0x400-0xFFF, the rest at 0x1800-0x1FFF.
  function automatic logic [22:0] map_addr(input logic [3:0] s, input logic [8:0] i);
    logic [12:0] o;
    logic [12:0] off;
    o   = {s, i};
    off = (o < 13'h0C00) ? o + 13'h0400 : o + 13'h0C00;
    return NVRAM_BASE | {10'd0, off};
  endfunction

  logic       buf_we;
  logic [8:0] buf_waddr;
  logic [7:0] buf_wdata;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = idx;
    buf_wdata = mem_din;
    if (state == LD_XFER) begin
      buf_we    = sd_buff_wr;
      buf_waddr = sd_buff_addr;
      buf_wdata = sd_buff_dout;
    end else if (state == SV_FILL) begin
      buf_we = phase & mem_ack;
    end
  end

  // NOTE: the sector buffer has no reset so it can map onto block RAM; it is always
  // fully rewritten (or deliberately left stale) before it is read.
  always_ff @(posedge clk) begin
    if (buf_we) sbuf[buf_waddr] <= buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      mounted      <= 1'b0;
      pending_load <= 1'b0;
      pending_save <= 1'b0;
      sec          <= '0;
      idx          <= '0;
      phase        <= 1'b0;
      sd_lba       <= '0;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      sd_buff_din  <= '0;
      mem_addr     <= '0;
      mem_dout     <= '0;
      mem_we       <= 1'b0;
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      dirty        <= 1'b0;
    end else begin
      if (state == SV_REQ || state == SV_XFER) sd_buff_din <= sbuf[sd_buff_addr];

      case (state)
        IDLE: begin
          if (pending_load) begin
            pending_load <= 1'b0;
            sec          <= '0;
            sd_lba       <= '0;
            sd_rd        <= 1'b1;
            busy         <= 1'b1;
            state        <= LD_REQ;
          end else if (pending_save) begin
            pending_save <= 1'b0;
            dirty        <= 1'b0;
            sec          <= '0;
            idx          <= '0;
            phase        <= 1'b0;
            busy         <= 1'b1;
            state        <= SV_FILL;
          end
        end
        LD_REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            state <= LD_XFER;
          end
        end
        LD_XFER: begin
          if (!sd_ack) begin
            idx   <= '0;
            phase <= 1'b0;
            state <= LD_COPY;
          end
        end
        LD_COPY: begin
          // phase 0 fetches the buffer byte with mem_req low; phase 1 holds the request.
          if (!phase) begin
            mem_addr <= map_addr(sec, idx);
            mem_dout <= sbuf[idx];
            mem_we   <= 1'b1;
            mem_req  <= 1'b1;
            phase    <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            phase   <= 1'b0;
            if (!last_byte) begin
              idx <= idx + 9'd1;
            end else if (last_sec) begin
              dirty <= 1'b0;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              sec    <= sec + 4'd1;
              sd_lba <= {28'd0, sec + 4'd1};
              sd_rd  <= 1'b1;
              state  <= LD_REQ;
            end
          end
        end
        SV_FILL: begin
          if (!phase) begin
            mem_addr <= map_addr(sec, idx);
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            phase    <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            phase   <= 1'b0;
            if (!last_byte) begin
              idx <= idx + 9'd1;
            end else begin
              idx    <= '0;
              sd_lba <= {28'd0, sec};
              sd_wr  <= 1'b1;
              state  <= SV_REQ;
            end
          end
        end
        SV_REQ: begin
          if (sd_ack) begin
            sd_wr <= 1'b0;
            state <= SV_XFER;
          end
        end
        SV_XFER: begin
          if (!sd_ack) begin
            if (last_sec) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              sec   <= sec + 4'd1;
              idx   <= '0;
              phase <= 1'b0;
              state <= SV_FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Host events come last so a pulse landing on a start cycle is never lost.
      if (save_req && mounted && !img_readonly && dirty) pending_save <= 1'b1;
      if (img_mounted) begin
        mounted <= (img_size != 32'd0);
        if (img_size != 32'd0) begin
          pending_load <= 1'b1;
        end else begin
          pending_load <= 1'b0;
          pending_save <= 1'b0;
        end
      end
      if (nvram_wr) dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_megacart_nvram_ctrl.sv
// Scoreboard bench for megacart_nvram_ctrl: SDRAM and SD host models, expected
// traffic queued at stimulus time and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_megacart_nvram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        img_mounted;
  logic [31:0] img_size;
  logic        img_readonly;
  logic        save_req;
  logic        nvram_wr;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;
  logic [22:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic        busy;
  logic        dirty;

  megacart_nvram_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
    .save_req(save_req), .nvram_wr(nvram_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_we(mem_we), .mem_req(mem_req), .mem_ack(mem_ack),
    .busy(busy), .dirty(dirty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_memwr = 0;
  int n_rd_hs = 0;
  int n_wr_hs = 0;
  logic host_rd_phase = 1'b0;

  logic [30:0] exp_mem_q [$];
  logic [32:0] exp_sd_q [$];
  logic [7:0]  exp_host_q [$];

  logic [7:0] sdram [8192];
  bit         written [8192];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Packed image offset to SDRAM byte address, written from the two window ranges.
  function automatic logic [22:0] exp_addr(input int s, input int i);
    int o;
    o = s * 512 + i;
    if (o < 3072) return 23'h400400 + 23'(o);
    return 23'h401800 + 23'(o - 3072);
  endfunction

  task automatic push_load();
    for (int s = 0; s < 10; s++) begin
      exp_sd_q.push_back({1'b0, 32'(s)});
      for (int i = 0; i < 512; i++) exp_mem_q.push_back({exp_addr(s, i), 8'(i) ^ 8'(s)});
    end
  endtask

  task automatic push_save();
    for (int s = 0; s < 10; s++) begin
      exp_sd_q.push_back({1'b1, 32'(s)});
      for (int i = 0; i < 512; i++) exp_host_q.push_back(8'(i) ^ 8'(s));
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a write, handshake or host byte.
  initial begin
    logic [30:0] em;
    logic [32:0] es;
    logic [7:0]  eh;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_req && mem_ack && mem_we) begin
          n_memwr++;
          if (exp_mem_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mem_write_unexpected: addr %0h data %0h", mem_addr, mem_dout);
          end else begin
            em = exp_mem_q.pop_front();
            check("mem_write", {mem_addr, mem_dout}, em);
          end
        end
        if (sd_ack && (sd_rd || sd_wr)) begin
          if (sd_rd) n_rd_hs++;
          if (sd_wr) n_wr_hs++;
          if (exp_sd_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sd_handshake_unexpected: wr %0b lba %0d", sd_wr, sd_lba);
          end else begin
            es = exp_sd_q.pop_front();
            check("sd_handshake", {sd_wr, sd_lba}, es);
          end
        end
        if (host_rd_phase) begin
          if (exp_host_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL host_byte_unexpected: got %0h", sd_buff_din);
          end else begin
            eh = exp_host_q.pop_front();
            check("host_byte", sd_buff_din, eh);
          end
        end
        if ((sd_rd && sd_wr) || (mem_req && (sd_ack || sd_rd || sd_wr))) begin
          n_cmp++; n_err++;
          $display("FAIL protocol: sd_rd %0b sd_wr %0b sd_ack %0b mem_req %0b",
                   sd_rd, sd_wr, sd_ack, mem_req);
        end
      end
    end
  end

  // SDRAM model: acknowledges each request one cycle after it appears.
  initial begin
    for (int a = 0; a < 8192; a++) sdram[a] = 8'hEE;
    mem_ack = 1'b0;
    mem_din = 8'h00;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          sdram[mem_addr[12:0]]   = mem_dout;
          written[mem_addr[12:0]] = 1'b1;
        end else begin
          mem_din = sdram[mem_addr[12:0]];
        end
      end
    end
  end

  // SD host model: load sectors carry byte i ^ lba; save sectors are read back byte by byte.
  initial begin
    sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (sd_rd && !sd_ack) begin
        sd_ack = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 512; a++) begin
          sd_buff_addr = 9'(a);
          sd_buff_dout = 8'(a) ^ sd_lba[7:0];
          sd_buff_wr   = 1'b1;
          @(posedge clk); #1;
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
      end else if (sd_wr && !sd_ack) begin
        sd_ack       = 1'b1;
        sd_buff_addr = '0;
        for (int a = 0; a < 512; a++) begin
          @(posedge clk); #1;
          host_rd_phase = 1'b1;
          sd_buff_addr  = 9'(a + 1);
        end
        @(posedge clk); #1;
        host_rd_phase = 1'b0;
        sd_ack        = 1'b0;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_mount(input logic [31:0] size);
    img_size = size; img_mounted = 1'b1; tick(); img_mounted = 1'b0;
  endtask

  task automatic pulse_save();
    save_req = 1'b1; tick(); save_req = 1'b0;
  endtask

  task automatic pulse_nvwr();
    nvram_wr = 1'b1; tick(); nvram_wr = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int max);
    int c = 0;
    while (!busy && c < max) begin tick(); c++; end
    check(name, busy, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int max);
    int c = 0;
    while (busy && c < max) begin tick(); c++; end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_lba(input int n);
    int c = 0;
    while (!(sd_ack && sd_lba == 32'(n)) && c < 20000) begin tick(); c++; end
    check($sformatf("reach_lba%0d", n), {sd_ack, sd_lba}, {1'b1, 32'(n)});
  endtask

  task automatic quiet(input string name, input int n);
    int act = 0;
    repeat (n) begin
      tick();
      if (busy || mem_req || sd_rd || sd_wr) act++;
    end
    check(name, act, 0);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_flags"}, {busy, dirty, sd_rd, sd_wr, mem_req, mem_we}, 6'b0);
    check({pfx, "_sd_lba"}, sd_lba, 32'h0);
    check({pfx, "_mem_addr"}, mem_addr, 23'h0);
    check({pfx, "_data"}, {mem_dout, sd_buff_din}, 16'h0);
  endtask

  initial begin
    int rd0, wr0, w0, bad, c;
    reset_n = 1'b0; img_mounted = 1'b0; img_size = '0; img_readonly = 1'b0;
    save_req = 1'b0; nvram_wr = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    quiet("idle_after_reset", 10);

    // Full load of a 5K image.
    push_load();
    rd0 = n_rd_hs; w0 = n_memwr;
    pulse_mount(32'd5120);
    wait_busy("load1_busy_rise", 4);
    wait_idle("load1_done", 20000);
    check("load1_rd_handshakes", n_rd_hs - rd0, 10);
    check("load1_mem_writes", n_memwr - w0, 5120);
    check("load1_mem_left", exp_mem_q.size(), 0);
    check("load1_sd_left", exp_sd_q.size(), 0);
    check("sdram_400400", sdram['h0400], 8'h00);
    check("sdram_400fff", sdram['h0FFF], 8'hFA);
    check("sdram_401800", sdram['h1800], 8'h06);
    check("sdram_401fff", sdram['h1FFF], 8'hF6);
    bad = 0;
    for (int a = 0; a < 'h400; a++) if (written[a]) bad++;
    for (int a = 'h1000; a < 'h1800; a++) if (written[a]) bad++;
    check("untouched_regions", bad, 0);
    check("load1_dirty", dirty, 1'b0);

    // Save gating: clean and read-only saves are ignored.
    pulse_save();
    quiet("save_ignored_clean", 20);
    pulse_nvwr();
    check("dirty_after_nvram_wr", dirty, 1'b1);
    img_readonly = 1'b1;
    pulse_save();
    quiet("save_ignored_readonly", 20);
    img_readonly = 1'b0;

    // Save with a VIC write landing in sector 4.
    push_save();
    wr0 = n_wr_hs;
    pulse_save();
    wait_busy("save1_busy_rise", 4);
    wait_lba(2);
    check("save1_dirty_snapshot", dirty, 1'b0);
    wait_lba(4);
    pulse_nvwr();
    wait_idle("save1_done", 20000);
    check("save1_wr_handshakes", n_wr_hs - wr0, 10);
    check("save1_host_left", exp_host_q.size(), 0);
    check("save1_sd_left", exp_sd_q.size(), 0);
    check("save1_dirty_after", dirty, 1'b1);

    // Second save; pending save cancelled by unmount, then a latched remount load follows.
    push_save();
    push_load();
    pulse_save();
    wait_busy("save2_busy_rise", 4);
    wait_lba(1);
    pulse_nvwr();
    wait_lba(2);
    pulse_save();
    wait_lba(3);
    pulse_mount(32'd0);
    wait_lba(5);
    pulse_mount(32'd5120);
    wait_idle("save2_done", 20000);
    check("gap_dirty", dirty, 1'b1);
    c = 0;
    while (!busy && c < 10) begin tick(); c++; end
    check("latched_load_gap", c, 1);
    wait_idle("load2_done", 20000);
    check("load2_mem_left", exp_mem_q.size(), 0);
    check("load2_host_left", exp_host_q.size(), 0);
    check("load2_sd_left", exp_sd_q.size(), 0);
    check("load2_dirty", dirty, 1'b0);
    quiet("no_save_after_unmount", 30);

    // Reset in the middle of copying sector 3, byte 100.
    push_load();
    w0 = n_memwr;
    pulse_mount(32'd5120);
    c = 0;
    while (n_memwr - w0 < 3 * 512 + 100 && c < 20000) begin tick(); c++; end
    check("reset_point_addr", mem_addr, exp_addr(3, 99));
    reset_n = 1'b0;
    tick();
    check_outputs_zero("midop_reset");
    exp_mem_q.delete();
    exp_sd_q.delete();
    tick();
    reset_n = 1'b1;
    quiet("no_mem_after_reset", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/megacart_nvram_ctrl.md
Name: megacart_nvram_ctrl

Overview:
- Sequences MegaCart NVRAM load and save between the MiSTer SD image interface and the 8K NVRAM region in SDRAM.
- Unmangles the sparse SDRAM layout into a packed 5K image file: 10 sectors of 512 bytes.
- Sits beside the MegaCart address wedge and owns the SDRAM port while busy. The top level uses busy to mux the port away from the VIC and hold the CPU.

Parameters:
- NVRAM_BASE, 23'h400000, SDRAM byte address of NVRAM offset 0; 8K aligned.
- SECTORS, 10, image length in 512-byte sectors.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- img_mounted  in  1  pulse; image (un)mounted
- img_size  in  32  image size in bytes, valid with img_mounted
- img_readonly  in  1  image is write-protected
- save_req  in  1  pulse; request save
- nvram_wr  in  1  pulse per VIC write to NVRAM (mc_nvram_sel & ~mc_wr_n)
- sd_lba  out  32  sector number
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  host acknowledge, high during transfer
- sd_buff_addr  in  9  host byte index
- sd_buff_dout  in  8  host-to-core data
- sd_buff_din  out  8  core-to-host data
- sd_buff_wr  in  1  host data strobe
- mem_addr  out  23  SDRAM byte address
- mem_dout  out  8  write data
- mem_din  in  8  read data, valid with mem_ack
- mem_we  out  1  write enable, qualified by mem_req
- mem_req  out  1  request, held until mem_ack
- mem_ack  in  1  one-cycle completion pulse
- busy  out  1  transfer in progress
- dirty  out  1  NVRAM modified since last load/save

Behaviour:
- Reset values: all outputs 0; state IDLE; mounted=0, pending_load=0, pending_save=0. Reset mid-transfer aborts immediately and drops sd_rd, sd_wr and mem_req in the same cycle.
- Address map, image offset o (13 bit, 0..5119):
  - o < 0xC00: off = o + 0x400
  - otherwise: off = o + 0xC00
  - mem_addr = NVRAM_BASE | off
  - Image 0x000 = NVRAM 0x400; image 0xBFF = 0xFFF; image 0xC00 = 0x1800; image 0x13FF = 0x1FFF.
- img_mounted: mounted <= (img_size != 0). If img_size != 0, set pending_load, otherwise clear pending_load and pending_save. A pulse during busy is latched and serviced after the current transfer.
- save_req: sets pending_save only if mounted & ~img_readonly & dirty; otherwise ignored.
- nvram_wr: sets dirty on any cycle, including during a save.
- Internal 512x8 sector buffer; read latency 1 cycle.
- Sector counter s (0..SECTORS-1); byte counter i (0..511); o = s*512 + i. sd_lba = s, zero-extended.
- IDLE: pending_load has priority over pending_save.
  - Load start: clear pending_load, s=0, go to LD_REQ.
  - Save start: clear pending_save and dirty (snapshot), s=0, go to SV_FILL.
  - busy=1 in every state except IDLE.
- LD_REQ: sd_rd=1 until sd_ack rises, then LD_XFER.
- LD_XFER: on sd_buff_wr, buf[sd_buff_addr] <= sd_buff_dout. When sd_ack falls, i=0, go to LD_COPY.
- LD_COPY: mem_req=1, mem_we=1, mem_dout=buf[i].
  - On mem_ack, i++.
  - After i=511 acked: s++. If s was SECTORS-1, clear dirty and go to IDLE; else go to LD_REQ.
  - mem_req deasserts for at least 1 cycle between bytes while the next buffer byte is fetched.
- SV_FILL: mem_req=1, mem_we=0. On mem_ack, buf[i] <= mem_din and i++. After i=511, go to SV_REQ.
- SV_REQ: sd_wr=1 until sd_ack rises, then SV_XFER.
- SV_XFER: sd_buff_din = buf[sd_buff_addr], registered, 1 cycle. When sd_ack falls: s++. If s was SECTORS-1, go to IDLE; else go to SV_FILL.
- Host transfers shorter than 512 strobes: unwritten buffer bytes keep stale contents. No error is flagged.
- sd_rd and sd_wr are never high together. mem_req is never high in LD_REQ, LD_XFER, SV_REQ or SV_XFER.

Test Plan:
- Load: mount with img_size=5120. Host returns byte=o[7:0]^s for each sector.
  - Required: busy rises; exactly 10 sd_rd handshakes with lba 0..9; 5120 mem writes.
  - SDRAM 0x400400 = 0x00, 0x400FFF = 0xFF^5, 0x401800 = 0x00^6, 0x401FFF = 0xFF^9.
  - 0x400000..0x4003FF and 0x401000..0x4017FF untouched; dirty=0; busy falls.
- Save gating: save_req with dirty=0 → no activity. Then nvram_wr pulse and save_req → 10 sd_wr handshakes.
  - Host receives the same bytes as the load, mapping inverted. dirty=0 at end.
- Write during save: nvram_wr in sector 4 of a save → dirty=1 after busy falls. A second save_req is accepted.
- Read-only/unmount: img_readonly=1 → save_req ignored.
  - Mount with img_size=0 while pending_save is set → pending cleared, no transfer.
- Latched mount: img_mounted pulse during a save → save completes, then a load starts with no idle gap beyond 1 cycle.
- Reset mid-op: reset_n low during LD_COPY at s=3, i=100 → next cycle all outputs 0, state IDLE. No further mem_req after reset is released.
